alu_ctrl_fsm: RTL and testbench

Parametrised ALU instruction sequencer. It sits between the instruction register and the register file / ALU datapath. For one ALU instruction it steps operand loads, execution, result writeback and PC increment. Compared with the fixed 16-bit ALU controller, it adds:
- generic field widths;
- a register-immediate class;
- a start/busy handshake;
- multi-cycle ALU ops with a ready handshake and a timeout.

---
 rtl/alu_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// ALU instruction sequencer: steps operand loads, execute, optional multi-cycle wait,
// writeback and PC increment for one captured instruction word.
module alu_ctrl_fsm #(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned RX_W        = 4,
    parameter int unsigned ALU_OP_W    = 4,
    parameter logic [(2**ALU_OP_W)-1:0] MC_OPS = '0,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                aluReady,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                fault,
    output logic [RX_W-1:0]     rxOut,
    output logic                rxOutEN,
    output logic [RX_W-1:0]     immOut,
    output logic                immEN,
    output logic                ALUin0,
    output logic                ALUin1,
    output logic [ALU_OP_W-1:0] aluOp,
    output logic                aluGo,
    output logic                ALUoutlatch,
    output logic                ALUoutEN,
    output logic [RX_W-1:0]     rxIn,
    output logic                rxInEN,
    output logic                pcInc,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD0, S_LOAD1, S_EXEC, S_WAIT, S_LATCH, S_WB, S_DONE
    } state_t;

    localparam logic [3:0] CLS_ALU  = 4'b1000;
    localparam logic [3:0] CLS_ALUI = 4'b1001;
    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;
    logic                 fault_q, fault_d;

    logic [3:0]           cls_in, ir_cls;
    logic [ALU_OP_W-1:0]  ir_op;
    logic [RX_W-1:0]      ir_rx, ir_ry;
    logic                 ir_multi;

    assign cls_in   = instruction[INSTR_W-1 -: 4];
    assign ir_cls   = ir_q[INSTR_W-1 -: 4];
    assign ir_op    = ir_q[INSTR_W-5 -: ALU_OP_W];
    assign ir_rx    = ir_q[2*RX_W-1:RX_W];
    assign ir_ry    = ir_q[RX_W-1:0];
    assign ir_multi = MC_OPS[ir_op];
    assign state_o  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d = instruction;
                    if (cls_in == CLS_ALU || cls_in == CLS_ALUI) begin
                        state_d = S_LOAD0;
                    end else begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = S_EXEC;
            S_EXEC: begin
                if (ir_multi) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a timeout on the same cycle.
                if (aluReady) begin
                    state_d = S_LATCH;
                end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end
            end
            S_LATCH: state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE: begin
                state_d   = S_IDLE;
                illegal_d = 1'b0;
                fault_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        illegal     = 1'b0;
        fault       = 1'b0;
        rxOut       = '0;
        rxOutEN     = 1'b0;
        immOut      = '0;
        immEN       = 1'b0;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        aluOp       = '0;
        aluGo       = 1'b0;
        ALUoutlatch = 1'b0;
        ALUoutEN    = 1'b0;
        rxIn        = '0;
        rxInEN      = 1'b0;
        pcInc       = 1'b0;
        case (state_q)
            S_LOAD0: begin
                aluOp   = ir_op;
                rxOut   = ir_rx;
                rxOutEN = 1'b1;
                ALUin0  = 1'b1;
            end
            S_LOAD1: begin
                aluOp  = ir_op;
                ALUin1 = 1'b1;
                if (ir_cls == CLS_ALUI) begin
                    immOut = ir_ry;
                    immEN  = 1'b1;
                end else begin
                    rxOut   = ir_ry;
                    rxOutEN = 1'b1;
                end
            end
            S_EXEC: begin
                aluOp       = ir_op;
                aluGo       = 1'b1;
                ALUoutlatch = !ir_multi;
            end
            S_WAIT: aluOp = ir_op;
            S_LATCH: begin
                aluOp       = ir_op;
                ALUoutlatch = 1'b1;
            end
            S_WB: begin
                aluOp    = ir_op;
                ALUoutEN = 1'b1;
                rxIn     = ir_rx;
                rxInEN   = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                pcInc   = 1'b1;
                illegal = illegal_q;
                fault   = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: random and directed instructions, per-cycle expected output
// trace from a reference model, popped and compared by a negedge monitor.
module tb_alu_ctrl_fsm;

  localparam int T = 8;
  localparam logic [15:0] MC = 16'h8004;

  typedef struct packed {
    logic       busy, done, illegal, fault;
    logic [3:0] rx_out;
    logic       rx_out_en;
    logic [3:0] imm_out;
    logic       imm_en, alu_in0, alu_in1;
    logic [3:0] alu_op;
    logic       alu_go, out_latch, out_en;
    logic [3:0] rx_in;
    logic       rx_in_en, pc_inc;
  } obs_t;
  localparam int W = $bits(obs_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT
  logic        start, aluReady;
  logic [15:0] instruction;
  logic        busy, done, illegal, fault, rxOutEN, immEN, ALUin0, ALUin1;
  logic        aluGo, ALUoutlatch, ALUoutEN, rxInEN, pcInc;
  logic [3:0]  rxOut, immOut, aluOp, rxIn;
  logic [2:0]  dbg_state;
  obs_t        act;

  // no-timeout DUT
  logic        start_n, ready_n;
  logic [15:0] instr_n;
  logic        busy_n, done_n, illegal_n, fault_n, rxOutEN_n, immEN_n, ALUin0_n, ALUin1_n;
  logic        aluGo_n, ALUoutlatch_n, ALUoutEN_n, rxInEN_n, pcInc_n;
  logic [3:0]  rxOut_n, immOut_n, aluOp_n, rxIn_n;
  logic [2:0]  dbg_state_n;
  obs_t        act_n;

  alu_ctrl_fsm #(.INSTR_W(16), .RX_W(4), .ALU_OP_W(4), .MC_OPS(MC), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction), .aluReady(aluReady),
    .busy(busy), .done(done), .illegal(illegal), .fault(fault),
    .rxOut(rxOut), .rxOutEN(rxOutEN), .immOut(immOut), .immEN(immEN),
    .ALUin0(ALUin0), .ALUin1(ALUin1), .aluOp(aluOp), .aluGo(aluGo),
    .ALUoutlatch(ALUoutlatch), .ALUoutEN(ALUoutEN), .rxIn(rxIn), .rxInEN(rxInEN),
    .pcInc(pcInc), .state_o(dbg_state)
  );

  alu_ctrl_fsm #(.INSTR_W(16), .RX_W(4), .ALU_OP_W(4), .MC_OPS(16'h0004), .TIMEOUT_CYC(0)) dut_nt (
    .clk(clk), .rst(rst), .start(start_n), .instruction(instr_n), .aluReady(ready_n),
    .busy(busy_n), .done(done_n), .illegal(illegal_n), .fault(fault_n),
    .rxOut(rxOut_n), .rxOutEN(rxOutEN_n), .immOut(immOut_n), .immEN(immEN_n),
    .ALUin0(ALUin0_n), .ALUin1(ALUin1_n), .aluOp(aluOp_n), .aluGo(aluGo_n),
    .ALUoutlatch(ALUoutlatch_n), .ALUoutEN(ALUoutEN_n), .rxIn(rxIn_n), .rxInEN(rxInEN_n),
    .pcInc(pcInc_n), .state_o(dbg_state_n)
  );

  assign act = {busy, done, illegal, fault, rxOut, rxOutEN, immOut, immEN, ALUin0, ALUin1,
                aluOp, aluGo, ALUoutlatch, ALUoutEN, rxIn, rxInEN, pcInc};
  assign act_n = {busy_n, done_n, illegal_n, fault_n, rxOut_n, rxOutEN_n, immOut_n, immEN_n,
                  ALUin0_n, ALUin1_n, aluOp_n, aluGo_n, ALUoutlatch_n, ALUoutEN_n, rxIn_n,
                  rxInEN_n, pcInc_n};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
  endtask

  function automatic obs_t busy_op(input logic [3:0] op);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.alu_op = op;
    return o;
  endfunction

  // Reference: the list of per-cycle outputs an instruction produces after its start edge.
  // k = index (1-based) of the first waiting cycle in which aluReady is high.
  task automatic model_push(input logic [15:0] ins, input int k, output int len);
    obs_t o;
    logic [3:0] cls, op, rx, ry;
    logic multi, timed_out;
    int n_wait;
    cls = ins[15:12]; op = ins[11:8]; rx = ins[7:4]; ry = ins[3:0];
    len = 0;
    if (cls != 4'h8 && cls != 4'h9) begin
      o = '0; o.busy = 1; o.done = 1; o.illegal = 1; o.pc_inc = 1;
      exp_q.push_back(o); len = 1;
      return;
    end
    o = busy_op(op); o.rx_out = rx; o.rx_out_en = 1; o.alu_in0 = 1;
    exp_q.push_back(o);
    o = busy_op(op); o.alu_in1 = 1;
    if (cls == 4'h8) begin o.rx_out = ry; o.rx_out_en = 1; end
    else begin o.imm_out = ry; o.imm_en = 1; end
    exp_q.push_back(o);
    multi = MC[op];
    o = busy_op(op); o.alu_go = 1; o.out_latch = !multi;
    exp_q.push_back(o);
    len = 3;
    timed_out = 1'b0;
    if (multi) begin
      timed_out = (T != 0) && (k > T);
      n_wait = timed_out ? T : k;
      for (int i = 0; i < n_wait; i++) begin
        exp_q.push_back(busy_op(op)); len++;
      end
      if (!timed_out) begin
        o = busy_op(op); o.out_latch = 1;
        exp_q.push_back(o); len++;
      end
    end
    if (!timed_out) begin
      o = busy_op(op); o.out_en = 1; o.rx_in = rx; o.rx_in_en = 1;
      exp_q.push_back(o); len++;
    end
    o = '0; o.busy = 1; o.done = 1; o.pc_inc = 1; o.fault = timed_out;
    exp_q.push_back(o); len++;
  endtask

  // monitor: a busy cycle consumes one expected entry; idle cycles must be all-zero
  always @(negedge clk) begin
    if (act.busy) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_busy: got %0h expected no activity at %0t", act, $time);
      end else begin
        check("trace", act, exp_q.pop_front());
      end
    end else begin
      check("idle_outputs", act, '0);
    end
  end

  // ---------------- driver ----------------
  task automatic run_instr(input logic [15:0] ins, input int k);
    int len;
    model_push(ins, k, len);
    start = 1'b1;
    instruction = ins;
    aluReady = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int i = 1; i <= len; i++) begin
      start = 1'($urandom_range(0, 1));
      instruction = 16'($urandom);
      if (i >= 4 && i < 3 + k) aluReady = 1'b0;
      else if (i == 3 + k)     aluReady = 1'b1;
      else                     aluReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    aluReady = 1'($urandom_range(0, 1));
  endtask

  task automatic abort_test();
    int len;
    model_push(16'h8212, 100, len);
    start = 1'b1; instruction = 16'h8212; aluReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_outputs", act, '0);
    check("abort_state", dbg_state, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic no_timeout_test();
    obs_t e;
    start_n = 1'b1; instr_n = 16'h8212; ready_n = 1'b0;
    @(posedge clk); #1;
    start_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      check("nt_wait", act_n, busy_op(4'h2));
      @(posedge clk); #1;
    end
    ready_n = 1'b1;
    @(posedge clk); #1;
    ready_n = 1'b0;
    e = busy_op(4'h2); e.out_latch = 1;
    check("nt_latch", act_n, e);
    @(posedge clk); #1;
    e = busy_op(4'h2); e.out_en = 1; e.rx_in = 4'h1; e.rx_in_en = 1;
    check("nt_wb", act_n, e);
    @(posedge clk); #1;
    e = '0; e.busy = 1; e.done = 1; e.pc_inc = 1;
    check("nt_done", act_n, e);
    @(posedge clk); #1;
    check("nt_idle", act_n, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] cls, op;
    logic [15:0] ins;
    int guard;
    rst = 1'b1; start = 1'b1; instruction = 16'h8012; aluReady = 1'b0;
    start_n = 1'b0; instr_n = '0; ready_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", act, '0);
    check("reset_state", dbg_state, 3'd0);
    check("reset_outputs_nt", act_n, '0);
    check("reset_state_nt", dbg_state_n, 3'd0);
    rst = 1'b0;
    // start still held high: the first edge after reset release accepts it
    run_instr(16'h8012, 1);
    run_instr(16'h9135, 1);
    run_instr(16'h8212, 3);
    run_instr(16'h8212, 100);
    run_instr(16'h8212, T);
    run_instr(16'h8212, T + 1);
    run_instr(16'h3012, 1);
    run_instr(16'h9F7A, 1);
    run_instr(16'h8F34, 1);
    abort_test();
    run_instr(16'h8012, 1);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cls = 4'h8;
        4, 5, 6, 7: cls = 4'h9;
        default:    cls = 4'($urandom);
      endcase
      op = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h2 : 4'hF)
                                       : 4'($urandom);
      ins = {cls, op, 8'($urandom)};
      run_instr(ins, $urandom_range(1, T + 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    no_timeout_test();
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
